alu: RTL and testbench
======================

Name: alu

Overview:
- 16-bit registered arithmetic/logic unit for the project's CR16-style datapath.
- Takes two operands, A and B, and an 8-bit opcode.
- Produces a 16-bit result C and five status flags: Carry, Flag, Low, Negative and Zero.
- Results and flags are captured on the clock. The flags persist between operations so the processor can use them for conditional branches.

Parameters:
- WIDTH, 16: operand and result width. All behaviour below assumes 16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all registers.
- A  input  16  operand A (destination-register value).
- B  input  16  operand B (source register or immediate value).
- Opcode  input  8  operation select.
- C  output  16  registered result.
- Carry  output  1  registered carry/borrow flag.
- Flag  output  1  registered signed-overflow flag.
- Low  output  1  registered unsigned less-than flag.
- Negative  output  1  registered signed less-than flag.
- Zero  output  1  registered equal flag.

Behaviour:
- Reset
  - Asserting reset immediately forces C = 0x0000 and all five flags to 0, regardless of clk.
  - Reset is fully asynchronous and overrides any concurrent edge.
- Latency and timing
  - Inputs are sampled on each rising clk edge while reset is low; C and the flags reflect that operation after the edge (1-cycle latency).
  - The block performs one operation per cycle, with no handshake.
  - A flag not listed for an operation holds its previous value.
- Opcode map (result C; flags updated):
  - 0x01 AND: C = A & B; no flags.
  - 0x02 OR: C = A | B; no flags.
  - 0x03 XOR: C = A ^ B; no flags.
  - 0x05 ADD: C = A + B mod 2^16; Carry = bit 16 of the sum; Flag = signed overflow (operands same sign, result sign differs).
  - 0x06 ADDU: C = A + B; Carry only.
  - 0x07 ADDC: C = A + B + Carry (current registered Carry); Carry and Flag as for ADD.
  - 0x09 SUB: C = A - B; Carry = 1 when A < B unsigned (borrow); Flag = signed overflow (operands differ in sign, result sign differs from A).
  - 0x0A SUBC: C = A - B - Carry; Carry = borrow of the full subtraction; Flag as for SUB.
  - 0x0B CMP: C = A - B; Zero = (A == B); Low = (A < B unsigned); Negative = (A < B signed). Carry and Flag are not updated.
  - 0x0D MOV: C = B; no flags.
  - 0x0E MUL: C = low 16 bits of A*B (unsigned); no flags.
  - 0x84 LSH: shift A by the signed amount B[4:0]; positive shifts left, negative shifts right logical; magnitude saturates at 15 (−16 treated as −15); zero fill; no flags.
  - 0x86 ASHU: as LSH, but right shifts replicate A[15]; no flags.
  - Any other opcode: C = 0x0000; all flags hold.
- Arithmetic and width rules
  - All arithmetic wraps modulo 2^16.
  - Internal sums and differences are computed at 17 bits to derive Carry.
  - ADDC/SUBC use the Carry value registered before the current edge.

Test Plan:
- Reset: assert reset mid-cycle with A=0xFFFF, B=0x0001, Opcode=0x05 → C=0, all flags 0 immediately, no clock edge needed; outputs stay 0 while reset is held.
- ADD carry/overflow:
  - A=0xFFFF, B=0x0001, ADD → C=0x0000, Carry=1, Flag=0.
  - A=0x7FFF, B=0x0001, ADD → C=0x8000, Carry=0, Flag=1.
- SUB and chaining:
  - A=0x0000, B=0x0001, SUB → C=0xFFFF, Carry=1.
  - Next cycle: A=5, B=2, SUBC → C=0x0002.
  - ADDC after a Carry=1 operation: A=1, B=1 → C=0x0003.
- CMP: first perform ADD 0x7FFF+1 (Flag=1), then compare:
  - A=0x0003, B=0x8000 → Zero=0, Low=1, Negative=0; Carry/Flag unchanged (Flag still 1).
  - A=B=0x1234 → Zero=1, Low=0, Negative=0.
- Logic/MOV/MUL:
  - A=0x00FF, B=0x0F0F: XOR → 0x0FF0, AND → 0x000F, OR → 0x0FFF, MOV → 0x0F0F, with flags held.
  - MUL A=0x0100, B=0x0101 → C=0x0100.
- Shifts and illegal opcode:
  - LSH A=0x8001, B=1 → 0x0002.
  - LSH A=0x8001, B=0x001F (−1) → 0x4000.
  - ASHU A=0x8000, B=0x001E (−2) → 0xE000.
  - Opcode 0xFF → C=0x0000, flags unchanged.
  - Plus 10 random A/B pairs with opcode 0x03, checked against a reference XOR.

Source files
------------

// File: rtl/alu.sv
// 16-bit registered ALU for the CR16-style datapath: one operation per clock,
// with status flags that hold between operations for conditional branches.
module alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [7:0]       Opcode,
  output logic [WIDTH-1:0] C,
  output logic             Carry,
  output logic             Flag,
  output logic             Low,
  output logic             Negative,
  output logic             Zero
);

  typedef enum logic [7:0] {
    OP_AND  = 8'h01,
    OP_OR   = 8'h02,
    OP_XOR  = 8'h03,
    OP_ADD  = 8'h05,
    OP_ADDU = 8'h06,
    OP_ADDC = 8'h07,
    OP_SUB  = 8'h09,
    OP_SUBC = 8'h0A,
    OP_CMP  = 8'h0B,
    OP_MOV  = 8'h0D,
    OP_MUL  = 8'h0E,
    OP_LSH  = 8'h84,
    OP_ASHU = 8'h86
  } op_t;

  op_t              op;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] prod;
  logic [4:0]       amt;
  logic [4:0]       negamt;
  logic [3:0]       mag;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] shr;
  logic [WIDTH-1:0] sar;
  logic             add_ovf;
  logic             sub_ovf;

  logic [WIDTH-1:0] c_n;
  logic             carry_n, flag_n, low_n, neg_n, zero_n;

  assign op   = op_t'(Opcode);
  assign cin  = ((op == OP_ADDC) || (op == OP_SUBC)) ? Carry : 1'b0;
  assign sum  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin};
  assign diff = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, cin};
  assign prod = A * B;

  assign add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1]  != A[WIDTH-1]);
  assign sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);

  // Right-shift magnitude is the negated 5-bit amount; -16 negates to 16 and saturates to 15.
  assign amt    = B[4:0];
  assign negamt = 5'd0 - amt;
  assign mag    = negamt[4] ? 4'd15 : negamt[3:0];
  assign shl    = A << amt[3:0];
  assign shr    = A >> mag;
  assign sar    = $unsigned($signed(A) >>> mag);

  always_comb begin
    c_n     = '0;
    carry_n = Carry;
    flag_n  = Flag;
    low_n   = Low;
    neg_n   = Negative;
    zero_n  = Zero;
    case (op)
      OP_AND:  c_n = A & B;
      OP_OR:   c_n = A | B;
      OP_XOR:  c_n = A ^ B;
      OP_ADD, OP_ADDC: begin
        c_n     = sum[WIDTH-1:0];
        carry_n = sum[WIDTH];
        flag_n  = add_ovf;
      end
      OP_ADDU: begin
        c_n     = sum[WIDTH-1:0];
        carry_n = sum[WIDTH];
      end
      OP_SUB, OP_SUBC: begin
        c_n     = diff[WIDTH-1:0];
        carry_n = diff[WIDTH];
        flag_n  = sub_ovf;
      end
      OP_CMP: begin
        c_n    = diff[WIDTH-1:0];
        zero_n = (A == B);
        low_n  = (A < B);
        neg_n  = ($signed(A) < $signed(B));
      end
      OP_MOV:  c_n = B;
      OP_MUL:  c_n = prod;
      OP_LSH:  c_n = amt[4] ? shr : shl;
      OP_ASHU: c_n = amt[4] ? sar : shl;
      default: c_n = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      C        <= '0;
      Carry    <= 1'b0;
      Flag     <= 1'b0;
      Low      <= 1'b0;
      Negative <= 1'b0;
      Zero     <= 1'b0;
    end else begin
      C        <= c_n;
      Carry    <= carry_n;
      Flag     <= flag_n;
      Low      <= low_n;
      Negative <= neg_n;
      Zero     <= zero_n;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed and random operations compared against
// an integer-arithmetic reference model of the opcode rules.
module tb_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] A, B;
  logic [7:0]  Opcode;
  logic [15:0] C;
  logic        Carry, Flag, Low, Negative, Zero;

  int checks = 0;
  int errors = 0;

  // Reference state
  int m_c;
  bit m_carry, m_flag, m_low, m_neg, m_zero;

  alu #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .Opcode(Opcode),
    .C(C), .Carry(Carry), .Flag(Flag), .Low(Low), .Negative(Negative), .Zero(Zero)
  );

  always #5 clk = ~clk;

  function automatic int sgn(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  function automatic bit out_of_range(input int v);
    return (v > 32767) || (v < -32768);
  endfunction

  function automatic void model_reset();
    m_c = 0; m_carry = 0; m_flag = 0; m_low = 0; m_neg = 0; m_zero = 0;
  endfunction

  function automatic void model_step(input int op, input int a, input int b);
    int     r;
    int     s;
    longint p;
    case (op)
      'h01: m_c = a & b;
      'h02: m_c = a | b;
      'h03: m_c = a ^ b;
      'h05, 'h07: begin
        r = a + b + ((op == 'h07) ? int'(m_carry) : 0);
        s = sgn(a) + sgn(b) + ((op == 'h07) ? int'(m_carry) : 0);
        m_c = r % 65536; m_carry = (r > 65535); m_flag = out_of_range(s);
      end
      'h06: begin
        r = a + b; m_c = r % 65536; m_carry = (r > 65535);
      end
      'h09, 'h0A: begin
        r = a - b - ((op == 'h0A) ? int'(m_carry) : 0);
        m_carry = (r < 0);
        m_c = (r + 131072) % 65536;
        m_flag = ((a >= 32768) != (b >= 32768)) && ((m_c >= 32768) != (a >= 32768));
      end
      'h0B: begin
        m_c = (a - b + 65536) % 65536;
        m_zero = (a == b); m_low = (a < b); m_neg = (sgn(a) < sgn(b));
      end
      'h0D: m_c = b;
      'h0E: begin
        p = longint'(a) * longint'(b); m_c = int'(p % 65536);
      end
      'h84, 'h86: begin
        s = b % 32;
        if (s >= 16) s = s - 32;
        if (s < -15) s = -15;
        if (s >= 0)          m_c = (a << s) % 65536;
        else if (op == 'h84) m_c = a >> (-s);
        else                 m_c = (sgn(a) >>> (-s)) & 'hFFFF;
      end
      default: m_c = 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".C"},   C,               16'(m_c));
    chk({tag, ".Cy"},  {15'b0, Carry},    {15'b0, m_carry});
    chk({tag, ".F"},   {15'b0, Flag},     {15'b0, m_flag});
    chk({tag, ".L"},   {15'b0, Low},      {15'b0, m_low});
    chk({tag, ".N"},   {15'b0, Negative}, {15'b0, m_neg});
    chk({tag, ".Z"},   {15'b0, Zero},     {15'b0, m_zero});
  endtask

  task automatic do_op(input string tag, input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    Opcode = op; A = a; B = b;
    @(posedge clk);
    #1;
    model_step(int'(op), int'(a), int'(b));
    chk_all(tag);
  endtask

  initial begin
    logic [15:0] ra, rb;
    reset = 1'b1; A = '0; B = '0; Opcode = '0;
    model_reset();
    #12;
    chk_all("por");
    @(negedge clk); reset = 1'b0;

    do_op("add_cy", 8'h05, 16'hFFFF, 16'h0001);
    chk("add_cy.lit", {C[14:0], Carry}, 16'h0001);
    do_op("add_ov", 8'h05, 16'h7FFF, 16'h0001);
    chk("add_ov.lit", {Flag, C[14:0]}, 16'h8000);
    do_op("sub",    8'h09, 16'h0000, 16'h0001);
    chk("sub.lit", C, 16'hFFFF);
    do_op("subc",   8'h0A, 16'h0005, 16'h0002);
    chk("subc.lit", C, 16'h0002);
    do_op("add_c1", 8'h05, 16'hFFFF, 16'h0001);
    do_op("addc",   8'h07, 16'h0001, 16'h0001);
    chk("addc.lit", C, 16'h0003);
    do_op("addu",   8'h06, 16'hFFFF, 16'h0002);

    do_op("add_f1", 8'h05, 16'h7FFF, 16'h0001);
    do_op("cmp_lt", 8'h0B, 16'h0003, 16'h8000);
    chk("cmp_lt.lit", {12'b0, Flag, Zero, Low, Negative}, 16'b1010);
    do_op("cmp_eq", 8'h0B, 16'h1234, 16'h1234);
    chk("cmp_eq.lit", {13'b0, Zero, Low, Negative}, 16'b100);
    do_op("cmp_sg", 8'h0B, 16'hFFFE, 16'h0001);

    do_op("xor", 8'h03, 16'h00FF, 16'h0F0F);
    chk("xor.lit", C, 16'h0FF0);
    do_op("and", 8'h01, 16'h00FF, 16'h0F0F);
    chk("and.lit", C, 16'h000F);
    do_op("or",  8'h02, 16'h00FF, 16'h0F0F);
    chk("or.lit", C, 16'h0FFF);
    do_op("mov", 8'h0D, 16'h00FF, 16'h0F0F);
    chk("mov.lit", C, 16'h0F0F);
    do_op("mul", 8'h0E, 16'h0100, 16'h0101);
    chk("mul.lit", C, 16'h0100);

    do_op("lsh_l1",  8'h84, 16'h8001, 16'h0001);
    chk("lsh_l1.lit", C, 16'h0002);
    do_op("lsh_r1",  8'h84, 16'h8001, 16'h001F);
    chk("lsh_r1.lit", C, 16'h4000);
    do_op("ashu_r2", 8'h86, 16'h8000, 16'h001E);
    chk("ashu_r2.lit", C, 16'hE000);
    do_op("lsh_m16", 8'h84, 16'h8000, 16'h0010);
    chk("lsh_m16.lit", C, 16'h0001);
    do_op("ashu_m16", 8'h86, 16'h8000, 16'h0010);
    chk("ashu_m16.lit", C, 16'hFFFF);
    do_op("lsh_l15", 8'h84, 16'h0001, 16'h000F);
    do_op("ashu_l3", 8'h86, 16'h1001, 16'h0003);

    do_op("add_pre", 8'h05, 16'h7FFF, 16'h8001);
    do_op("illegal", 8'hFF, 16'h1234, 16'h5678);
    chk("illegal.lit", C, 16'h0000);

    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      do_op("rnd_xor", 8'h03, ra, rb);
    end

    do_op("pre_rst", 8'h05, 16'h7FFF, 16'h0001);
    @(posedge clk);
    #3;
    A = 16'hFFFF; B = 16'h0001; Opcode = 8'h05;
    reset = 1'b1;
    #1;
    model_reset();
    chk_all("rst_async");
    repeat (2) @(posedge clk);
    #1;
    chk_all("rst_hold");
    @(negedge clk); reset = 1'b0;
    do_op("post_rst", 8'h05, 16'hFFFF, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
